// File: rtl/serial_adder_if.sv
// Operand/result bundle for serial_adder: the requester drives start and operands,
// the adder returns busy, the done pulse and the registered result.
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] y;
  logic             cout;

  modport master (output start, a, b, cin, input busy, done, y, cout);
  modport slave  (input start, a, b, cin, output busy, done, y, cout);
endinterface

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder slice and a carry flop consume the operands
// LSB first, one bit per clock, and publish {cout, y} with a one-cycle done pulse.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  serial_adder_if.slave  bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {IDLE, ADD} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             sum_bit;
  logic             carry_out;

  assign sum_bit   = opa_q[0] ^ opb_q[0] ^ carry_q;
  assign carry_out = (opa_q[0] & opb_q[0]) | ((opa_q[0] | opb_q[0]) & carry_q);

  always_comb begin
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    res_d   = res_q;
    y_d     = y_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          opa_d   = bus.a;
          opb_d   = bus.b;
          carry_d = bus.cin;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = ADD;
        end
      end
      ADD: begin
        opa_d   = opa_q >> 1;
        opb_d   = opb_q >> 1;
        res_d   = {sum_bit, res_q[WIDTH-1:1]};
        carry_d = carry_out;
        cnt_d   = cnt_q + CW'(1);
        // Last slice: publish the freshly shifted result rather than waiting a cycle.
        if (cnt_q == CW'(WIDTH - 1)) begin
          y_d     = {sum_bit, res_q[WIDTH-1:1]};
          cout_d  = carry_out;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      res_q   <= '0;
      y_q     <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      res_q   <= res_d;
      y_q     <= y_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.y    = y_q;
  assign bus.cout = cout_q;
endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder at WIDTH=8 and WIDTH=16: vector table,
// hand-written corner sequences and a randomized sweep against plain integer addition.
module tb_serial_adder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  serial_adder_if #(.WIDTH(8))  b8 ();
  serial_adder_if #(.WIDTH(16)) b16 ();

  serial_adder #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(b8.slave));
  serial_adder #(.WIDTH(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(b16.slave));

  int total  = 0;
  int passed = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] exp_y;
    logic       exp_cout;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s actual=%0h required=%0h", name, act, exp);
  endtask

  task automatic drive(input int w, input logic s, input logic [15:0] a, input logic [15:0] b,
                       input logic c);
    if (w == 8) begin
      b8.start = s; b8.a = a[7:0]; b8.b = b[7:0]; b8.cin = c;
    end else begin
      b16.start = s; b16.a = a; b16.b = b; b16.cin = c;
    end
  endtask

  task automatic sample(input int w, output logic bz, output logic dn, output logic [15:0] y,
                        output logic co);
    if (w == 8) begin
      bz = b8.busy; dn = b8.done; y = {8'h00, b8.y}; co = b8.cout;
    end else begin
      bz = b16.busy; dn = b16.done; y = b16.y; co = b16.cout;
    end
  endtask

  // One complete addition; glitch_at > 0 pulses a bogus Start mid-operation.
  task automatic op(input int w, input logic [15:0] a, input logic [15:0] b, input logic cin,
                    input int glitch_at, input string name);
    int sum, mask, lat;
    bit seen;
    logic [15:0] py, y;
    logic pc, bz, dn, co, pbz, pdn;
    mask = (1 << w) - 1;
    sum  = int'(a) + int'(b) + int'(cin);
    lat  = 0;
    seen = 1'b0;
    @(negedge clk);
    sample(w, pbz, pdn, py, pc);
    drive(w, 1'b1, a, b, cin);
    @(posedge clk); #1;
    drive(w, 1'b0, 16'($urandom), 16'($urandom), 1'($urandom));
    sample(w, bz, dn, y, co);
    chk({name, "_busy_start"}, int'(bz), 1);
    while (!seen && lat < w + 4) begin
      @(posedge clk); #1;
      lat++;
      if (lat == glitch_at) drive(w, 1'b1, 16'hFFFF, 16'hFFFF, 1'b1);
      else if (lat == glitch_at + 1) drive(w, 1'b0, 16'($urandom), 16'($urandom), 1'b0);
      sample(w, bz, dn, y, co);
      if (dn) seen = 1'b1;
      else begin
        chk({name, "_hold_y"}, int'(y), int'(py));
        chk({name, "_hold_cout"}, int'(co), int'(pc));
        chk({name, "_busy_run"}, int'(bz), 1);
      end
    end
    chk({name, "_done_seen"}, int'(seen), 1);
    if (seen) begin
      chk({name, "_latency"}, lat, w);
      chk({name, "_y"}, int'(y), sum & mask);
      chk({name, "_cout"}, int'(co), (sum >> w) & 1);
      chk({name, "_busy_done"}, int'(bz), 0);
    end
    @(posedge clk); #1;
    sample(w, bz, dn, y, co);
    chk({name, "_done_single"}, int'(dn), 0);
    chk({name, "_idle_after"}, int'(bz), 0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[8];
    logic bz, dn, co;
    logic [15:0] y;
    int last, nd;

    tbl[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0};
    tbl[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    tbl[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    tbl[3] = '{8'h03, 8'h04, 1'b1, 8'h08, 1'b0};
    tbl[4] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    tbl[5] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    tbl[6] = '{8'h7F, 8'h00, 1'b1, 8'h80, 1'b0};
    tbl[7] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};

    drive(8, 1'b0, 16'h0, 16'h0, 1'b0);
    drive(16, 1'b0, 16'h0, 16'h0, 1'b0);
    #12;
    sample(8, bz, dn, y, co);
    chk("rst8_busy", int'(bz), 0); chk("rst8_done", int'(dn), 0);
    chk("rst8_y", int'(y), 0);     chk("rst8_cout", int'(co), 0);
    sample(16, bz, dn, y, co);
    chk("rst16_busy", int'(bz), 0); chk("rst16_done", int'(dn), 0);
    chk("rst16_y", int'(y), 0);     chk("rst16_cout", int'(co), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table vectors: expected sums worked out by hand.
    for (int i = 0; i < 8; i++) begin
      op(8, {8'h00, tbl[i].a}, {8'h00, tbl[i].b}, tbl[i].cin, -10, $sformatf("vec%0d", i));
      sample(8, bz, dn, y, co);
      chk($sformatf("vec%0d_tbl_y", i), int'(y), int'(tbl[i].exp_y));
      chk($sformatf("vec%0d_tbl_cout", i), int'(co), int'(tbl[i].exp_cout));
    end

    op(8, 16'h0010, 16'h0020, 1'b0, 2, "ignore_start");
    sample(8, bz, dn, y, co);
    chk("ignore_start_y30", int'(y), 8'h30);

    // Start held high: a new addition begins in every Done cycle.
    @(negedge clk);
    drive(8, 1'b1, 16'h0001, 16'h0001, 1'b0);
    last = 0;
    nd = 0;
    for (int c = 1; c <= 28; c++) begin
      @(posedge clk); #1;
      sample(8, bz, dn, y, co);
      chk("b2b_busy_vs_done", int'(bz), int'(!dn));
      if (dn) begin
        nd++;
        chk("b2b_gap", c - last, 9);
        chk("b2b_y", int'(y), 2);
        last = c;
      end
    end
    chk("b2b_done_count", nd, 3);
    drive(8, 1'b0, 16'h0, 16'h0, 1'b0);
    repeat (10) @(posedge clk);

    // Reset in the middle of an addition.
    @(negedge clk);
    drive(8, 1'b1, 16'h00AA, 16'h0055, 1'b0);
    @(posedge clk); #1;
    drive(8, 1'b0, 16'h0, 16'h0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    sample(8, bz, dn, y, co);
    chk("abort_busy_before", int'(bz), 1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    sample(8, bz, dn, y, co);
    chk("abort_busy", int'(bz), 0); chk("abort_done", int'(dn), 0);
    chk("abort_y", int'(y), 0);     chk("abort_cout", int'(co), 0);
    drive(8, 1'b1, 16'h00FF, 16'h00FF, 1'b1);
    repeat (2) @(negedge clk);
    drive(8, 1'b0, 16'h0, 16'h0, 1'b0);
    rst_n = 1'b1;
    nd = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      sample(8, bz, dn, y, co);
      if (dn || bz) nd++;
    end
    chk("abort_no_activity", nd, 0);
    op(8, 16'h0003, 16'h0004, 1'b1, -10, "after_abort");

    // Random sweep against integer addition.
    for (int i = 0; i < 1000; i++)
      op(8, 16'($urandom_range(0, 255)), 16'($urandom_range(0, 255)), 1'($urandom), -10, "rnd8");
    for (int i = 0; i < 1000; i++)
      op(16, 16'($urandom), 16'($urandom), 1'($urandom), -10, "rnd16");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
